// File: rtl/axil_mmio_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite MMIO register responder.
package axil_mmio_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT_W,
      W_WAIT_AW,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_t;

endpackage

// File: rtl/axil_strb_merge.sv
// Byte-lane merge: each lane takes the new byte when its strobe is set, else keeps the old byte.
module axil_strb_merge
   import axil_mmio_pkg::*;
(
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] new_word,
   input  logic [STRB_W-1:0] strb,
   output logic [DATA_W-1:0] merged_c
);

   always_comb begin
      merged_c = old_word;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (strb[b]) merged_c[8*b +: 8] = new_word[8*b +: 8];
      end
   end

endmodule

// File: rtl/axil_mmio_responder.sv
// AXI4-Lite responder exposing NUM_REGS read/write registers with per-register write strobes.
// Define AXIL_MMIO_ADDR_ERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_mmio_responder
   import axil_mmio_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 25,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16
) (
   input  logic                           sys_clk,
   input  logic                           sys_reset_n,
   input  logic                           s_axil_awvalid,
   output logic                           s_axil_awready,
   input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
   input  logic                           s_axil_wvalid,
   output logic                           s_axil_wready,
   input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
   output logic                           s_axil_bvalid,
   input  logic                           s_axil_bready,
   output logic [1:0]                     s_axil_bresp,
   input  logic                           s_axil_arvalid,
   output logic                           s_axil_arready,
   input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
   output logic                           s_axil_rvalid,
   input  logic                           s_axil_rready,
   output logic [DATA_WIDTH-1:0]          s_axil_rdata,
   output logic [1:0]                     s_axil_rresp,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int unsigned IDX_W      = $clog2(NUM_REGS);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

`ifdef AXIL_MMIO_ADDR_ERR_EN
   localparam logic [1:0] ADDR_ERR_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] ADDR_ERR_RESP = RESP_OKAY;
`endif

   w_state_t                w_state, w_next;
   r_state_t                r_state, r_next;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [STRB_WIDTH-1:0]   w_strb_q;
   logic                    aw_hs_c, w_hs_c, ar_hs_c, commit_c;
   logic [ADDR_WIDTH-1:0]   cm_addr_c;
   logic [DATA_WIDTH-1:0]   cm_data_c;
   logic [STRB_WIDTH-1:0]   cm_strb_c;
   logic [IDX_W-1:0]        cm_idx_c, rd_idx_c;
   logic                    cm_hit_c, rd_hit_c;
   logic [DATA_WIDTH-1:0]   merged_c;
   logic [NUM_REGS-1:0]     pulse_c;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic                    unused_addr_bits;

   assign aw_hs_c = s_axil_awvalid & s_axil_awready;
   assign w_hs_c  = s_axil_wvalid  & s_axil_wready;
   assign ar_hs_c = s_axil_arvalid & s_axil_arready;

   // Byte offset within a word carries no meaning for 32-bit registers.
   assign unused_addr_bits = ^{cm_addr_c[1:0], s_axil_araddr[1:0]};

   // Write FSM next state; commit fields come from the live bus or the half-captured side.
   always_comb begin
      w_next    = w_state;
      commit_c  = 1'b0;
      cm_addr_c = aw_addr_q;
      cm_data_c = w_data_q;
      cm_strb_c = w_strb_q;
      case (w_state)
         W_IDLE: begin
            if (aw_hs_c && w_hs_c) begin
               commit_c  = 1'b1;
               cm_addr_c = s_axil_awaddr;
               cm_data_c = s_axil_wdata;
               cm_strb_c = s_axil_wstrb;
               w_next    = W_RESP;
            end else if (aw_hs_c) begin
               w_next = W_WAIT_W;
            end else if (w_hs_c) begin
               w_next = W_WAIT_AW;
            end
         end
         W_WAIT_W: begin
            if (w_hs_c) begin
               commit_c  = 1'b1;
               cm_data_c = s_axil_wdata;
               cm_strb_c = s_axil_wstrb;
               w_next    = W_RESP;
            end
         end
         W_WAIT_AW: begin
            if (aw_hs_c) begin
               commit_c  = 1'b1;
               cm_addr_c = s_axil_awaddr;
               w_next    = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axil_bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      cm_idx_c = cm_addr_c[IDX_W+1:2];
      cm_hit_c = (cm_addr_c[ADDR_WIDTH-1:IDX_W+2] == '0);
      rd_idx_c = s_axil_araddr[IDX_W+1:2];
      rd_hit_c = (s_axil_araddr[ADDR_WIDTH-1:IDX_W+2] == '0);
      pulse_c  = '0;
      if (commit_c && cm_hit_c) pulse_c[cm_idx_c] = 1'b1;
   end

   axil_strb_merge u_merge (
      .old_word (regs_q[cm_idx_c]),
      .new_word (cm_data_c),
      .strb     (cm_strb_c),
      .merged_c (merged_c)
   );

   // Write channel state, ready/valid flags and response.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         w_state        <= W_IDLE;
         s_axil_awready <= 1'b1;
         s_axil_wready  <= 1'b1;
         s_axil_bvalid  <= 1'b0;
         s_axil_bresp   <= RESP_OKAY;
         aw_addr_q      <= '0;
         w_data_q       <= '0;
         w_strb_q       <= '0;
         wr_pulse_o     <= '0;
      end else begin
         w_state        <= w_next;
         s_axil_awready <= (w_next == W_IDLE) || (w_next == W_WAIT_AW);
         s_axil_wready  <= (w_next == W_IDLE) || (w_next == W_WAIT_W);
         s_axil_bvalid  <= (w_next == W_RESP);
         wr_pulse_o     <= pulse_c;
         if (aw_hs_c) aw_addr_q <= s_axil_awaddr;
         if (w_hs_c) begin
            w_data_q <= s_axil_wdata;
            w_strb_q <= s_axil_wstrb;
         end
         if (commit_c) s_axil_bresp <= cm_hit_c ? RESP_OKAY : ADDR_ERR_RESP;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (commit_c && cm_hit_c) begin
         regs_q[cm_idx_c] <= merged_c;
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs_c) r_next = R_RESP;
         R_RESP:  if (s_axil_rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Read data is sampled from the pre-commit register image, so a colliding write is not seen.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         r_state        <= R_IDLE;
         s_axil_arready <= 1'b1;
         s_axil_rvalid  <= 1'b0;
         s_axil_rdata   <= '0;
         s_axil_rresp   <= RESP_OKAY;
      end else begin
         r_state        <= r_next;
         s_axil_arready <= (r_next == R_IDLE);
         s_axil_rvalid  <= (r_next == R_RESP);
         if (ar_hs_c) begin
            s_axil_rdata <= rd_hit_c ? regs_q[rd_idx_c] : '0;
            s_axil_rresp <= rd_hit_c ? RESP_OKAY : ADDR_ERR_RESP;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
   end

endmodule

// File: tb/tb_axil_mmio_responder.sv
// Bench for axil_mmio_responder: vector table, directed multi-cycle sequences, randomized traffic vs. a register-file model.
module tb_axil_mmio_responder;

   localparam int unsigned AW = 25;
   localparam int unsigned NR = 16;
`ifdef AXIL_MMIO_ADDR_ERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   logic          sys_clk = 1'b0;
   logic          sys_reset_n;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [NR*32-1:0] regs;
   logic [NR-1:0] wr_pulse;

   axil_mmio_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
      .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
      .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
      .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
      .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
      .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
      .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
      .regs_o(regs), .wr_pulse_o(wr_pulse)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int failures = 0;
   logic [31:0] model [NR];

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [3:0]    strb;
      int            lead;     // >0: W leads AW by this many cycles, <0: AW leads W
      int            bdly;
      int            rdly;
      logic [31:0]   exp_rd;
      logic [1:0]    exp_resp;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit in_range(input logic [AW-1:0] a);
      return a < AW'(NR * 4);
   endfunction

   function automatic int idx_of(input logic [AW-1:0] a);
      return int'(a / 4) % NR;
   endfunction

   function automatic logic [511:0] model_vec();
      logic [511:0] v = '0;
      for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
      return v;
   endfunction

   task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] mask = '0;
      if (!in_range(a)) return;
      for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
      model[idx_of(a)] = (model[idx_of(a)] & ~mask) | (d & mask);
   endtask

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdly, output logic [1:0] resp);
      bit aw_p = 1'b1, w_p = 1'b1;
      int aw_s, w_s, cyc = 0;
      logic [NR-1:0] exp_pulse;
      aw_s = (lead > 0) ? lead : 0;
      w_s  = (lead < 0) ? -lead : 0;
      awaddr = a; wdata = d; wstrb = s;
      resp = 2'bxx;
      while ((aw_p || w_p) && cyc < 40) begin
         @(negedge sys_clk);
         awvalid = aw_p && (cyc >= aw_s);
         wvalid  = w_p && (cyc >= w_s);
         if (awvalid && awready) aw_p = 1'b0;
         if (wvalid && wready) w_p = 1'b0;
         cyc++;
      end
      if (aw_p || w_p) begin
         chk("wr_handshake_timeout", 1'b1, 1'b0);
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      exp_pulse = in_range(a) ? (NR'(1) << idx_of(a)) : '0;
      model_write(a, d, s);
      @(negedge sys_clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("bvalid_latency", bvalid, 1'b1);
      chk("wr_pulse", wr_pulse, exp_pulse);
      chk("regs_after_commit", regs, model_vec());
      resp = bresp;
      repeat (bdly) begin
         @(negedge sys_clk);
         chk("bvalid_hold", bvalid, 1'b1);
         chk("bresp_stable", bresp, resp);
         chk("ready_low_in_resp", {awready, wready}, 2'b00);
      end
      bready = 1'b1;
      @(negedge sys_clk);
      bready = 1'b0;
      chk("bvalid_clear", bvalid, 1'b0);
      chk("wr_pulse_one_cycle", wr_pulse, '0);
   endtask

   task automatic axi_read(input logic [AW-1:0] a, input int rdly,
                           output logic [31:0] d, output logic [1:0] resp);
      bit done = 1'b0;
      int cyc = 0;
      araddr = a;
      d = '0; resp = 2'bxx;
      while (!done && cyc < 40) begin
         @(negedge sys_clk);
         arvalid = 1'b1;
         if (arready) done = 1'b1;
         cyc++;
      end
      if (!done) begin
         chk("rd_handshake_timeout", 1'b1, 1'b0);
         arvalid = 1'b0;
         return;
      end
      @(negedge sys_clk);
      arvalid = 1'b0;
      chk("rvalid_latency", rvalid, 1'b1);
      d = rdata; resp = rresp;
      repeat (rdly) begin
         @(negedge sys_clk);
         chk("rvalid_hold", rvalid, 1'b1);
         chk("rdata_stable", rdata, d);
         chk("arready_low_in_resp", arready, 1'b0);
      end
      rready = 1'b1;
      @(negedge sys_clk);
      rready = 1'b0;
      chk("rvalid_clear", rvalid, 1'b0);
      chk("arready_back", arready, 1'b1);
   endtask

   initial begin
      logic [1:0]  resp, rr;
      logic [31:0] rd, old;
      logic [AW-1:0] a;
      int hs;

      tbl[0] = '{25'h08,      32'hDEADBEEF, 4'hF,  0, 0, 4, 32'hDEADBEEF, 2'b00};
      tbl[1] = '{25'h04,      32'hFFFFFFFF, 4'hF,  0, 5, 0, 32'hFFFFFFFF, 2'b00};
      tbl[2] = '{25'h04,      32'h12345678, 4'h3,  3, 0, 1, 32'hFFFF5678, 2'b00};
      tbl[3] = '{25'h0C,      32'hA5A5A5A5, 4'h0, -2, 1, 0, 32'h00000000, 2'b00};
      tbl[4] = '{25'h3F,      32'hCAFEF00D, 4'hC,  0, 0, 2, 32'hCAFE0000, 2'b00};
      tbl[5] = '{25'h40,      32'h11111111, 4'hF,  0, 0, 0, 32'h00000000, OOR_RESP};
      tbl[6] = '{25'h1000008, 32'h22222222, 4'hF,  2, 2, 1, 32'h00000000, OOR_RESP};
      tbl[7] = '{25'h08,      32'h00000055, 4'h1, -1, 0, 0, 32'hDEADBE55, 2'b00};

      for (int i = 0; i < NR; i++) model[i] = '0;
      sys_reset_n = 1'b0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      repeat (2) @(negedge sys_clk);
      chk("reset_regs", regs, '0);
      chk("reset_valids", {bvalid, rvalid}, 2'b00);
      chk("reset_pulse", wr_pulse, '0);
      chk("reset_rdata", rdata, '0);
      sys_reset_n = 1'b1;
      @(negedge sys_clk);
      chk("ready_after_reset", {awready, wready, arready}, 3'b111);

      for (int i = 0; i < 8; i++) begin
         axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].lead, tbl[i].bdly, resp);
         chk("tbl_bresp", resp, tbl[i].exp_resp);
         axi_read(tbl[i].addr, tbl[i].rdly, rd, rr);
         chk("tbl_rdata", rd, tbl[i].exp_rd);
         chk("tbl_rresp", rr, tbl[i].exp_resp);
      end

      // Read and write commit to register 4 in the same cycle.
      old = model[4];
      @(negedge sys_clk);
      awaddr = 25'h10; wdata = 32'h0BADCAFE; wstrb = 4'hF; araddr = 25'h10;
      awvalid = 1; wvalid = 1; arvalid = 1;
      chk("collide_ready", {awready, wready, arready}, 3'b111);
      @(negedge sys_clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      model_write(25'h10, 32'h0BADCAFE, 4'hF);
      chk("collide_rvalid", rvalid, 1'b1);
      chk("collide_rdata_old", rdata, old);
      chk("collide_bvalid", bvalid, 1'b1);
      bready = 1; rready = 1;
      @(negedge sys_clk);
      bready = 0; rready = 0;
      chk("collide_regs", regs, model_vec());

      // A second AW waits out a stalled B response.
      @(negedge sys_clk);
      awaddr = 25'h14; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      @(negedge sys_clk);
      model_write(25'h14, 32'h11112222, 4'hF);
      awaddr = 25'h18; wdata = 32'h33334444; wvalid = 0;
      repeat (5) begin
         chk("stall_bvalid", bvalid, 1'b1);
         chk("stall_awready", awready, 1'b0);
         @(negedge sys_clk);
      end
      bready = 1;
      @(negedge sys_clk);
      bready = 0;
      chk("stall_b_done", bvalid, 1'b0);
      chk("stall_aw_open", awready, 1'b1);
      @(negedge sys_clk);
      awvalid = 0;
      chk("stall_wait_w", {awready, wready}, 2'b01);
      wvalid = 1;
      @(negedge sys_clk);
      wvalid = 0;
      model_write(25'h18, 32'h33334444, 4'hF);
      chk("stall_second_bvalid", bvalid, 1'b1);
      bready = 1;
      @(negedge sys_clk);
      bready = 0;
      chk("stall_regs", regs, model_vec());

      // Back-to-back writes with bready held high: one per two cycles.
      hs = 0;
      awaddr = 25'h1C; wstrb = 4'hF;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);
         awvalid = 1; wvalid = 1; bready = 1;
         wdata = 32'h100 + 32'(hs);
         if (awready && wready) begin
            model_write(25'h1C, wdata, 4'hF);
            hs++;
         end
      end
      @(negedge sys_clk);
      awvalid = 0; wvalid = 0; bready = 0;
      chk("b2b_count", 32'(hs), 32'd4);
      chk("b2b_regs", regs, model_vec());

      // Reset while the write FSM holds a lone AW.
      @(negedge sys_clk);
      awaddr = 25'h08; awvalid = 1;
      @(negedge sys_clk);
      awvalid = 0;
      chk("half_aw_state", {awready, wready}, 2'b01);
      sys_reset_n = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) model[i] = '0;
      chk("async_reset_regs", regs, '0);
      chk("async_reset_bvalid", bvalid, 1'b0);
      @(negedge sys_clk);
      sys_reset_n = 1'b1;
      @(negedge sys_clk);
      chk("ready_after_reset2", {awready, wready, arready}, 3'b111);
      axi_write(25'h08, 32'h600DF00D, 4'hF, 0, 0, resp);
      chk("post_reset_bresp", resp, 2'b00);
      axi_read(25'h08, 0, rd, rr);
      chk("post_reset_rdata", rd, 32'h600DF00D);

      // Randomized traffic against the model.
      for (int n = 0; n < 60; n++) begin
         a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            logic [31:0] d;
            logic [3:0] s;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), resp);
            chk("rnd_bresp", resp, in_range(a) ? 2'b00 : OOR_RESP);
         end else begin
            axi_read(a, int'($urandom_range(0, 3)), rd, rr);
            chk("rnd_rdata", rd, in_range(a) ? model[idx_of(a)] : 32'h0);
            chk("rnd_rresp", rr, in_range(a) ? 2'b00 : OOR_RESP);
         end
      end
      chk("final_regs", regs, model_vec());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axil_mmio_responder.md
AXIL_MMIO_RESPONDER -- requirements
Module: axil_mmio_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25: AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of read/write registers; power of two, 2..256.
REQ-004 SHALL have one clock and an asynchronous, active-low reset (already decided):
  sys_clk  in  1  sole clock
  sys_reset_n  in  1  asynchronous active-low reset
REQ-005 SHALL have the following AXI4-Lite responder ports, prefix s_axil_:
  awvalid in 1, awready out 1, awaddr in ADDR_WIDTH
  wvalid in 1, wready out 1, wdata in 32, wstrb in 4
  bvalid out 1, bready in 1, bresp out 2
  arvalid in 1, arready out 1, araddr in ADDR_WIDTH
  rvalid out 1, rready in 1, rdata out 32, rresp out 2
REQ-006 SHALL have port regs_o  out  NUM_REGS*32: register contents; register i sits at bits [32i+31:32i].
REQ-007 SHALL have port wr_pulse_o  out  NUM_REGS: one-cycle strobe per register on write commit.

Function
REQ-008 SHALL decode register index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; the address is in range iff addr[ADDR_WIDTH-1:log2(NUM_REGS)+2] == 0.
REQ-009 Write FSM SHALL have states W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP.
REQ-010 In W_IDLE, awready=1 and wready=1.
- AW and W handshake in the same cycle -> commit, go to W_RESP.
- AW only -> latch awaddr, go to W_WAIT_W.
- W only -> latch wdata/wstrb, go to W_WAIT_AW.
REQ-011 W_WAIT_W SHALL assert only wready; W_WAIT_AW SHALL assert only awready; the completing handshake SHALL commit and go to W_RESP.
REQ-012 Commit SHALL update each in-range register byte whose wstrb bit is 1, and SHALL pulse wr_pulse_o[index] in the cycle after the commit handshake, coincident with the register update.
REQ-013 W_RESP SHALL hold bvalid=1 and a stable bresp until bready=1, then go to W_IDLE; awready=wready=0 while in W_RESP.
REQ-014 bvalid SHALL first assert the cycle after commit (latency 1); back-to-back writes SHALL achieve one write per 2 cycles when bready is held 1.
REQ-015 Read FSM SHALL have states R_IDLE (arready=1) and R_RESP (rvalid=1).
- AR handshake -> register rdata/rresp, go to R_RESP.
- In R_RESP, rready=1 -> go to R_IDLE.
- rdata SHALL remain stable while rvalid=1 and rready=0.
REQ-016 A read and a write commit to the same register in the same cycle SHALL return the pre-write value.
REQ-017 Read and write FSMs SHALL operate independently and concurrently.
REQ-018 In-range accesses SHALL return rresp/bresp = 2'b00.
REQ-019 wstrb = 0 SHALL complete with OKAY and modify nothing, and wr_pulse_o SHALL still fire.

Reset
REQ-020 Asserting sys_reset_n low SHALL, asynchronously:
- force both FSMs to their idle states;
- clear all registers, bvalid, rvalid, bresp, rresp, rdata and wr_pulse_o to 0;
- drop any half-captured AW/W and any pending response.
REQ-021 After sys_reset_n deasserts, awready, wready and arready SHALL be 1 on the first clock edge.

Configuration
REQ-022 With macro AXIL_MMIO_ADDR_ERR_EN defined, an out-of-range access SHALL return SLVERR (2'b10), rdata=0, with no register update and no pulse.
REQ-023 Without AXIL_MMIO_ADDR_ERR_EN, out-of-range writes SHALL be silently dropped with OKAY, and out-of-range reads SHALL return 0 with OKAY.

Structure
REQ-024 Package axil_mmio_pkg SHALL hold the AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and the write- and read-FSM state enum typedefs.
REQ-025 The byte-lane merge SHALL be one sub-module, axil_strb_merge (old word, new word, wstrb -> merged word); all else SHALL be flat.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- AW+W same cycle, addr 0x8, data 0xDEADBEEF, strb 0xF -> regs_o[2]=0xDEADBEEF; wr_pulse_o=0x0004 for 1 cycle; bvalid next cycle; bresp 0.
- W three cycles before AW, addr 0x4, strb 0x3, data 0x12345678 over 0xFFFFFFFF -> reg1=0xFFFF5678.
- bready held 0 for 5 cycles after a write -> bvalid stays 1; awready=wready=0; a second AW is not accepted until the B handshake.
- Read of 0x8 with rready low 4 cycles -> rdata=0xDEADBEEF stable throughout; arready=0 until R handshake.
- Write 0x40 (NUM_REGS=16) -> bresp 2'b10 with macro, 2'b00 without; all regs unchanged.
- sys_reset_n pulsed low while in W_WAIT_W -> regs cleared; next full write behaves normally.
